// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequencing ALU feeding the accumulator write port
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiply for opcode 0xB.
module alu_seq #(
    parameter int WIDTH     = 8,
    parameter int MUL_ITERS = WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             done,
    output logic             acc_we
);

    localparam int M = WIDTH - 1;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;
    state_t state, state_nxt;

    logic [3:0]       op_r;
    logic [WIDTH-1:0] a_r, b_r;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH:0]   ext;
    logic             alu_c, alu_v;

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = $clog2(MUL_ITERS + 1);
    logic [2*WIDTH-1:0] prod, prod_nxt;
    logic [WIDTH:0]     mul_sum;
    logic [CW-1:0]      cnt;
    logic               mul_last;

    // Multiplier sits in the low half of prod and is consumed one bit per iteration.
    assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_r} : '0);
    assign prod_nxt = {mul_sum, prod[WIDTH-1:1]};
    assign mul_last = (cnt == CW'(MUL_ITERS - 1));
`else
    localparam int unused_mul_iters = MUL_ITERS;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
`ifdef ALU_SEQ_MUL_EN
                    state_nxt = (op == 4'hB) ? S_MUL : S_EXEC;
`else
                    state_nxt = S_EXEC;
`endif
                end
            end
            S_EXEC: state_nxt = S_DONE;
`ifdef ALU_SEQ_MUL_EN
            S_MUL:  state_nxt = mul_last ? S_DONE : S_MUL;
`endif
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != S_IDLE);
        done   = (state == S_DONE);
        acc_we = (state == S_DONE);
    end

    // Single-cycle datapath; C is carry-out / borrow / shifted-out bit.
    always_comb begin
        alu_res = a_r;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        ext     = '0;
        case (op_r)
            4'h0: begin
                ext     = {1'b0, a_r} + {1'b0, b_r};
                alu_res = ext[M:0];
                alu_c   = ext[WIDTH];
                alu_v   = (a_r[M] == b_r[M]) && (alu_res[M] != a_r[M]);
            end
            4'h1: begin
                ext     = {1'b0, a_r} - {1'b0, b_r};
                alu_res = ext[M:0];
                alu_c   = ext[WIDTH];
                alu_v   = (a_r[M] != b_r[M]) && (alu_res[M] != a_r[M]);
            end
            4'h2: alu_res = a_r & b_r;
            4'h3: alu_res = a_r | b_r;
            4'h4: alu_res = a_r ^ b_r;
            4'h5: alu_res = ~a_r;
            4'h6: begin
                alu_res = {a_r[M-1:0], 1'b0};
                alu_c   = a_r[M];
            end
            4'h7: begin
                alu_res = {1'b0, a_r[M:1]};
                alu_c   = a_r[0];
            end
            4'h8: begin
                ext     = {1'b0, a_r} + (WIDTH+1)'(1);
                alu_res = ext[M:0];
                alu_c   = ext[WIDTH];
                alu_v   = alu_res[M] & ~a_r[M];
            end
            4'h9: begin
                ext     = {1'b0, a_r} - (WIDTH+1)'(1);
                alu_res = ext[M:0];
                alu_c   = ext[WIDTH];
                alu_v   = a_r[M] & ~alu_res[M];
            end
            4'hA: begin
                ext     = {1'b0, a_r} + {1'b0, b_r} + {{WIDTH{1'b0}}, flags[1]};
                alu_res = ext[M:0];
                alu_c   = ext[WIDTH];
                alu_v   = (a_r[M] == b_r[M]) && (alu_res[M] != a_r[M]);
            end
            default: alu_res = a_r;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            op_r      <= '0;
            a_r       <= '0;
            b_r       <= '0;
            result    <= '0;
            result_hi <= '0;
            flags     <= '0;
`ifdef ALU_SEQ_MUL_EN
            prod      <= '0;
            cnt       <= '0;
`endif
        end else begin
            if (state == S_IDLE && start) begin
                op_r <= op;
                a_r  <= a_in;
                b_r  <= b_in;
`ifdef ALU_SEQ_MUL_EN
                prod <= {{WIDTH{1'b0}}, b_in};
                cnt  <= '0;
`endif
            end
            if (state == S_EXEC) begin
                result    <= alu_res;
                result_hi <= '0;
                flags     <= {(alu_res == '0), alu_res[M], alu_c, alu_v};
            end
`ifdef ALU_SEQ_MUL_EN
            if (state == S_MUL) begin
                prod <= prod_nxt;
                cnt  <= cnt + CW'(1);
                if (mul_last) begin
                    result    <= prod_nxt[M:0];
                    result_hi <= prod_nxt[2*WIDTH-1:WIDTH];
                    flags     <= {(prod_nxt == '0), prod_nxt[M],
                                  (prod_nxt[2*WIDTH-1:WIDTH] != '0),
                                  (prod_nxt[2*WIDTH-1:WIDTH] != '0)};
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq against an arithmetic reference model
module tb_alu_seq;

`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       start = 1'b0;
    logic [3:0] op = 4'h0;
    logic [7:0] a_in = 8'h00, b_in = 8'h00;
    logic [7:0] result, result_hi;
    logic [3:0] flags;
    logic       busy, done, acc_we;

    alu_seq dut (
        .CLK(CLK), .RESET(RESET), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
        .result(result), .result_hi(result_hi), .flags(flags),
        .busy(busy), .done(done), .acc_we(acc_we)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         d;
        logic [7:0] r;
        logic [7:0] h;
        logic [3:0] f;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_pass = 0;
    int   free_e = 0, last_acc = 0, busy_until = 0;
    logic cflag = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic int sgn(input logic [7:0] x);
        return (x >= 8'd128) ? int'(x) - 256 : int'(x);
    endfunction

    function automatic exp_t model(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                                   input logic ci);
        int   r, sr;
        logic c, v;
        exp_t e;
        r = int'(a); sr = 0; c = 1'b0; v = 1'b0;
        e.h = 8'h00;
        case (o)
            4'h0: begin r = int'(a) + int'(b); c = (r > 255); sr = sgn(a) + sgn(b); v = (sr > 127 || sr < -128); end
            4'h1: begin r = int'(a) - int'(b); c = (a < b); sr = sgn(a) - sgn(b); v = (sr > 127 || sr < -128); end
            4'h2: r = int'(a & b);
            4'h3: r = int'(a | b);
            4'h4: r = int'(a ^ b);
            4'h5: r = 255 - int'(a);
            4'h6: begin r = int'(a) * 2; c = (a >= 8'd128); end
            4'h7: begin r = int'(a) / 2; c = (a % 2 == 1); end
            4'h8: begin r = int'(a) + 1; c = (r > 255); sr = sgn(a) + 1; v = (sr > 127); end
            4'h9: begin r = int'(a) - 1; c = (a == 8'd0); sr = sgn(a) - 1; v = (sr < -128); end
            4'hA: begin r = int'(a) + int'(b) + int'(ci); c = (r > 255); sr = sgn(a) + sgn(b) + int'(ci); v = (sr > 127 || sr < -128); end
            4'hB: if (MUL_ON) begin
                r = int'(a) * int'(b);
                e.h = 8'(r / 256);
                c = (e.h != 8'h00);
                v = c;
            end
            default: r = int'(a);
        endcase
        e.r = 8'(r & 255);
        e.f = {(e.r == 8'h00 && e.h == 8'h00), e.r[7], c, v};
        e.d = 0;
        return e;
    endfunction

    // Drive one clock's worth of inputs just after a rising edge and predict its effect.
    task automatic step(input logic rst, input logic st, input logic [3:0] o,
                        input logic [7:0] a, input logic [7:0] b);
        int   e, lat;
        exp_t x;
        @(posedge CLK);
        #1;
        RESET = rst; start = st; op = o; a_in = a; b_in = b;
        e = cyc + 1;
        if (rst) begin
            while (q.size() > 0 && q[q.size()-1].d >= e) void'(q.pop_back());
            if (busy_until > e) busy_until = e;
            free_e = e + 1;
            cflag  = 1'b0;
        end else if (st && e >= free_e) begin
            x = model(o, a, b, cflag);
            lat = (o == 4'hB && MUL_ON) ? 8 : 1;
            x.d = e + lat;
            q.push_back(x);
            cflag      = x.f[1];
            last_acc   = e;
            busy_until = e + lat + 1;
            free_e     = e + lat + 2;
        end
    endtask

    task automatic run(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
        step(1'b0, 1'b1, o, a, b);
        repeat ((o == 4'hB && MUL_ON) ? 10 : 3) step(1'b0, 1'b0, 4'h0, 8'h00, 8'h00);
    endtask

    task automatic chk_zero();
        @(negedge CLK);
        check("reset_result", result, 0);
        check("reset_result_hi", result_hi, 0);
        check("reset_flags", flags, 0);
    endtask

    always @(negedge CLK) begin
        logic exp_done;
        exp_t x;
        exp_done = (q.size() > 0) && (q[0].d == cyc);
        check("done", done, exp_done);
        check("acc_we", acc_we, exp_done);
        check("busy", busy, (cyc >= last_acc) && (cyc < busy_until));
        if (exp_done) begin
            x = q.pop_front();
            check("result", result, x.r);
            check("result_hi", result_hi, x.h);
            check("flags", flags, x.f);
        end
    end

    initial begin
        repeat (2) step(1'b1, 1'b0, 4'h0, 8'h00, 8'h00);
        step(1'b0, 1'b0, 4'h0, 8'h00, 8'h00);
        chk_zero();

        run(4'h0, 8'h7F, 8'h01);
        run(4'h1, 8'h05, 8'h06);
        run(4'hA, 8'h10, 8'h20);
        run(4'h7, 8'h01, 8'h00);
        run(4'h8, 8'hFF, 8'h00);
        run(4'h9, 8'h00, 8'h00);
        run(4'h6, 8'h80, 8'h00);
        run(4'hB, 8'hFF, 8'hFF);
        run(4'hB, 8'h00, 8'hFF);

        repeat (5) step(1'b0, 1'b1, 4'h2, 8'hF0, 8'h3C);
        repeat (4) step(1'b0, 1'b0, 4'h0, 8'h00, 8'h00);

        // Abort an operation in flight, then confirm a clean restart.
        step(1'b0, 1'b1, 4'hB, 8'hFF, 8'hFF);
        repeat (MUL_ON ? 3 : 0) step(1'b0, 1'b0, 4'h0, 8'h00, 8'h00);
        step(1'b1, 1'b0, 4'h0, 8'h00, 8'h00);
        step(1'b0, 1'b0, 4'h0, 8'h00, 8'h00);
        chk_zero();
        run(4'hB, 8'h12, 8'h34);

        repeat (600) begin
            step(($urandom_range(0, 149) == 0), ($urandom_range(0, 2) == 0),
                 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
        end
        repeat (12) step(1'b0, 1'b0, 4'h0, 8'h00, 8'h00);
        @(negedge CLK);
        check("drain", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
